pipe_ctrl: RTL and testbench

- Central hazard and stall controller for the 5-stage pipeline.
- Generates the 2-bit stall code for each inter-stage register: if_id, id_ex, ex_mem and mem_wb. Also generates the PC hold.
- Resolves load-use hazards, EX redirects, instruction-fetch misses, data-memory waits and multi-cycle EX operations.
- Tracks multi-cycle EX operations and in-flight stale fetches, and counts inserted bubbles.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a 5-stage pipeline.
// Produces per-register stall codes and PC hold, sequences multi-cycle EX
// operations, discards stale fetches after a redirect and counts bubbles.
module pipe_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_ren,
  input  logic             i_id_rs2_ren,
  input  logic             i_ex_mem_rena,
  input  logic [4:0]       i_ex_rd_waddr,
  input  logic             i_ex_redirect,
  input  logic             i_ex_multi,
  input  logic             i_if_busy,
  input  logic             i_mem_busy,
  output logic             o_pc_hold,
  output logic [1:0]       o_if_id_stall,
  output logic [1:0]       o_id_ex_stall,
  output logic [1:0]       o_ex_mem_stall,
  output logic [1:0]       o_mem_wb_stall,
  output logic             o_ex_multi_done,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam int unsigned CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic               w_lu;
  logic               w_done;
  logic               w_multi_act;
  logic               w_bubble;

  // Load-use hazard between the load in EX and the sources read in ID
  assign w_lu = i_ex_mem_rena && (i_ex_rd_waddr != 5'd0) &&
                ((i_id_rs1_ren && (i_id_rs1_addr == i_ex_rd_waddr)) ||
                 (i_id_rs2_ren && (i_id_rs2_addr == i_ex_rd_waddr)));

  assign w_done      = (r_state == ST_MULTI) && (r_cnt == '0);
  assign w_multi_act = (r_state == ST_MULTI) || ((r_state == ST_RUN) && i_ex_multi);

  // Prioritised stall-code selection; first matching cause wins
  always_comb begin
    o_pc_hold      = 1'b0;
    o_if_id_stall  = STALL_NEXT;
    o_id_ex_stall  = STALL_NEXT;
    o_ex_mem_stall = STALL_NEXT;
    o_mem_wb_stall = STALL_NEXT;
    w_bubble       = 1'b0;
    if (i_rst) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_ZERO;
      o_id_ex_stall  = STALL_ZERO;
      o_ex_mem_stall = STALL_ZERO;
      o_mem_wb_stall = STALL_ZERO;
    end else if (i_mem_busy) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_KEEP;
      o_id_ex_stall  = STALL_KEEP;
      o_ex_mem_stall = STALL_KEEP;
      o_mem_wb_stall = STALL_ZERO;
    end else if (w_multi_act && !w_done) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_KEEP;
      o_id_ex_stall  = STALL_KEEP;
      o_ex_mem_stall = STALL_ZERO;
    end else if (i_ex_redirect) begin
      o_if_id_stall  = STALL_ZERO;
      o_id_ex_stall  = STALL_ZERO;
      w_bubble       = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_ZERO;
    end else if (w_lu) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_KEEP;
      o_id_ex_stall  = STALL_ZERO;
      w_bubble       = 1'b1;
    end else if (i_if_busy) begin
      o_pc_hold      = 1'b1;
      o_if_id_stall  = STALL_ZERO;
    end
  end

  // Control FSM with multi-cycle occupancy counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (!i_mem_busy) begin
      unique case (r_state)
        ST_RUN: begin
          if (i_ex_multi) begin
            r_cnt   <= CW'(MULDIV_CYCLES - 1);
            r_state <= ST_MULTI;
          end else if (i_ex_redirect && i_if_busy) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_MULTI: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (i_ex_redirect && i_if_busy) begin
            r_state <= ST_FLUSH;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (!i_if_busy) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of bubbles inserted by redirects and load-use stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign o_ex_multi_done = w_done && !i_rst;
  assign o_ctrl_state    = r_state;
  assign o_bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MULDIV_CYCLES=4, CNT_W=4).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_waddr;
  logic       id_rs1_ren, id_rs2_ren, ex_mem_rena, ex_redirect, ex_multi;
  logic       if_busy, mem_busy;
  logic       pc_hold, ex_multi_done;
  logic [1:0] if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, ctrl_state;
  logic [3:0] bubble_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  pipe_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr),
    .i_id_rs1_ren(id_rs1_ren), .i_id_rs2_ren(id_rs2_ren),
    .i_ex_mem_rena(ex_mem_rena), .i_ex_rd_waddr(ex_rd_waddr),
    .i_ex_redirect(ex_redirect), .i_ex_multi(ex_multi),
    .i_if_busy(if_busy), .i_mem_busy(mem_busy),
    .o_pc_hold(pc_hold), .o_if_id_stall(if_id_stall), .o_id_ex_stall(id_ex_stall),
    .o_ex_mem_stall(ex_mem_stall), .o_mem_wb_stall(mem_wb_stall),
    .o_ex_multi_done(ex_multi_done), .o_ctrl_state(ctrl_state),
    .o_bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic pc, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(pc));
    chk({tag, ".if_id"},   32'(if_id_stall), 32'(a));
    chk({tag, ".id_ex"},   32'(id_ex_stall), 32'(b));
    chk({tag, ".ex_mem"},  32'(ex_mem_stall), 32'(c));
    chk({tag, ".mem_wb"},  32'(mem_wb_stall), 32'(d));
  endtask

  task automatic chk_regs(input string tag, input logic done, input logic [1:0] st,
                          input logic [3:0] bub);
    chk({tag, ".done"},   32'(ex_multi_done), 32'(done));
    chk({tag, ".state"},  32'(ctrl_state), 32'(st));
    chk({tag, ".bubble"}, 32'(bubble_cnt), 32'(bub));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_waddr = 5'd0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_mem_rena = 1'b0;
    ex_redirect = 1'b0; ex_multi = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_rena = 1'b1; ex_rd_waddr = 5'd5; id_rs2_ren = 1'b1; id_rs2_addr = 5'd5;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk_stall("reset", 1'b1, 2'b10, 2'b10, 2'b10, 2'b10);
    chk_regs("reset", 1'b0, 2'd0, 4'd0);
    tick();
    rst = 1'b0;
    #2;
    chk_stall("idle", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    // load-use on rs2
    set_lu();
    #2;
    chk_stall("lu_rs2", 1'b1, 2'b01, 2'b10, 2'b00, 2'b00);
    tick();
    idle();
    #2;
    chk_stall("lu_after", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_regs("lu_after", 1'b0, 2'd0, 4'd1);

    // rd = x0 never hazards
    set_lu(); ex_rd_waddr = 5'd0; id_rs2_addr = 5'd0;
    #2;
    chk_stall("lu_x0", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    chk_regs("lu_x0", 1'b0, 2'd0, 4'd1);

    // rs1 match only counts when rs1 is read
    idle(); ex_mem_rena = 1'b1; ex_rd_waddr = 5'd7; id_rs1_addr = 5'd7;
    #2;
    chk_stall("lu_rs1_noren", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    id_rs1_ren = 1'b1;
    #1;
    chk_stall("lu_rs1", 1'b1, 2'b01, 2'b10, 2'b00, 2'b00);
    tick();
    idle();
    #2;
    chk_regs("lu_rs1", 1'b0, 2'd0, 4'd2);

    // if_busy alone
    if_busy = 1'b1;
    #2;
    chk_stall("ifbusy", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    tick();
    idle();
    #2;
    chk_regs("ifbusy", 1'b0, 2'd0, 4'd2);

    // multi-cycle op: entry cycle in RUN, then MULTI cnt 3,2,1 stall, cnt 0 done
    ex_multi = 1'b1;
    #2;
    chk_stall("multi_entry", 1'b1, 2'b01, 2'b01, 2'b10, 2'b00);
    chk_regs("multi_entry", 1'b0, 2'd0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk_stall("multi_busy", 1'b1, 2'b01, 2'b01, 2'b10, 2'b00);
      chk_regs("multi_busy", 1'b0, 2'd1, 4'd2);
    end
    tick();
    #2;
    chk_stall("multi_done", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_regs("multi_done", 1'b1, 2'd1, 4'd2);
    ex_multi = 1'b0;
    tick();
    #2;
    chk_regs("multi_exit", 1'b0, 2'd0, 4'd2);

    // mem_busy freezes MULTI at cnt=2
    ex_multi = 1'b1;
    tick();
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_stall("mb_multi", 1'b1, 2'b01, 2'b01, 2'b01, 2'b10);
      chk_regs("mb_multi", 1'b0, 2'd1, 4'd2);
      tick();
    end
    mem_busy = 1'b0;
    #2;
    chk_stall("mb_rel0", 1'b1, 2'b01, 2'b01, 2'b10, 2'b00);
    tick();
    #2;
    chk_stall("mb_rel1", 1'b1, 2'b01, 2'b01, 2'b10, 2'b00);
    chk_regs("mb_rel1", 1'b0, 2'd1, 4'd2);
    tick();
    #2;
    chk_regs("mb_done", 1'b1, 2'd1, 4'd2);
    // mem_busy while done holds done and state
    mem_busy = 1'b1;
    #1;
    chk_stall("mb_at_done", 1'b1, 2'b01, 2'b01, 2'b01, 2'b10);
    tick();
    #2;
    chk_regs("mb_done_hold", 1'b1, 2'd1, 4'd2);
    mem_busy = 1'b0; ex_multi = 1'b0;
    tick();
    #2;
    chk_regs("mb_exit", 1'b0, 2'd0, 4'd2);

    // redirect with fetch outstanding -> FLUSH
    ex_redirect = 1'b1; if_busy = 1'b1;
    #2;
    chk_stall("redir", 1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
    tick();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_stall("flush_busy", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
      chk_regs("flush_busy", 1'b0, 2'd2, 4'd3);
      tick();
    end
    if_busy = 1'b0;
    #2;
    chk_stall("flush_drop", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_regs("flush_drop", 1'b0, 2'd2, 4'd3);
    tick();
    #2;
    chk_stall("flush_exit", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_regs("flush_exit", 1'b0, 2'd0, 4'd3);

    // redirect and load-use together: redirect wins, one bubble
    set_lu(); ex_redirect = 1'b1;
    #2;
    chk_stall("redir_lu", 1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
    tick();
    idle();
    #2;
    chk_regs("redir_lu", 1'b0, 2'd0, 4'd4);

    // redirect inside FLUSH keeps FLUSH while fetch busy
    ex_redirect = 1'b1; if_busy = 1'b1;
    tick();
    #2;
    chk_stall("flush_redir", 1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
    chk_regs("flush_redir", 1'b0, 2'd2, 4'd5);
    tick();
    ex_redirect = 1'b0; if_busy = 1'b0;
    #2;
    chk_regs("flush_redir2", 1'b0, 2'd2, 4'd6);
    tick();
    #2;
    chk_regs("flush_redir_exit", 1'b0, 2'd0, 4'd6);

    // saturation of the 4-bit bubble counter
    set_lu();
    for (int i = 0; i < 12; i++) begin
      #2;
      chk_stall("sat_lu", 1'b1, 2'b01, 2'b10, 2'b00, 2'b00);
      tick();
    end
    #2;
    chk_regs("sat", 1'b0, 2'd0, 4'd15);

    // async reset mid-MULTI
    idle(); ex_multi = 1'b1;
    tick();
    tick();
    #2;
    chk_regs("pre_rst", 1'b0, 2'd1, 4'd15);
    rst = 1'b1;
    #1;
    chk_stall("async_rst", 1'b1, 2'b10, 2'b10, 2'b10, 2'b10);
    chk_regs("async_rst", 1'b0, 2'd0, 4'd0);
    rst = 1'b0; ex_multi = 1'b0;
    tick();
    #2;
    chk_stall("post_rst", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_regs("post_rst", 1'b0, 2'd0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
